usr_tx_seq: RTL and testbench

Parallel-to-serial transmit sequencer built around a universal shift register core. Accepts a WIDTH-bit word on a valid/ready input handshake. Parallel-loads the word into the core, then issues shift commands one bit per accepted beat, LSB-first or MSB-first. Presents a serial valid/ready stream to downstream logic. Sits between a word-oriented producer and a bit-serial link.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_core.sv | 31 +++
 rtl/usr_tx_seq.sv | 133 +++++++++++++
 tb/tb_usr_tx_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared MODE and FSM-state encodings for the universal-shift-register transmit path.
// Latency: none, constants and a pure function only.
// Backpressure: not applicable, no handshakes in this package.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] PARITY = 2'b10;

    // LSB-first drains toward bit 0, MSB-first drains toward bit WIDTH-1.
    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/usr_core.sv
// Four-mode universal shift register: hold, shift right, shift left, parallel load.
// Latency: q reflects the selected operation one clock after mode is presented.
// Backpressure: none; the caller selects HOLD to stall.
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_SHR:  q <= {sin, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], sin};
                MODE_LOAD: q <= din;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/usr_tx_seq.sv
// Word-to-bit transmit sequencer; optional trailing even-parity beat under USR_TX_PARITY_EN.
// Latency: first bit valid the cycle after the word is accepted; WIDTH beats per word (WIDTH+1 with parity).
// Backpressure: ser_ready low freezes the core (HOLD), counter and outputs; in_ready only in IDLE.
module usr_tx_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic [1:0]       mode_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic [WIDTH-1:0] q;
    logic             data_last;
`ifdef USR_TX_PARITY_EN
    logic             par_q;
`endif

    assign data_last = (state == SHIFT) && (cnt == LAST_CNT);
    assign in_ready  = (state == IDLE) && !reset;
    assign ser_valid = (state != IDLE);
    assign busy      = (state != IDLE);

`ifdef USR_TX_PARITY_EN
    assign ser_last = (state == PARITY);
`else
    assign ser_last = data_last;
`endif

    always_comb begin
        mode_out  = MODE_HOLD;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mode_out  = MODE_LOAD;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    mode_out = shift_mode(dir_q);
                    if (data_last) begin
`ifdef USR_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef USR_TX_PARITY_EN
            PARITY: begin
                if (ser_ready) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        // The core must not see LOAD while it is being cleared.
        if (reset) begin
            mode_out = MODE_HOLD;
        end
    end

    always_comb begin
        ser_out = 1'b0;
        if (state == SHIFT) begin
            ser_out = dir_q ? q[WIDTH-1] : q[0];
        end
`ifdef USR_TX_PARITY_EN
        else if (state == PARITY) begin
            ser_out = par_q;
        end
`endif
    end

    // The counter parks on the last index instead of wrapping; the next load clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                cnt   <= '0;
                dir_q <= in_dir;
            end else if (state == SHIFT && ser_ready && cnt != LAST_CNT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef USR_TX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            par_q <= ^in_data;
        end
    end
`endif

    usr_core #(.WIDTH(WIDTH)) u_core (
        .clock (clock),
        .reset (reset),
        .mode  (mode_out),
        .din   (in_data),
        .sin   (1'b0),
        .q     (q)
    );

endmodule

// File: tb/tb_usr_tx_seq.sv
// Bench for usr_tx_seq: directed scenarios plus randomized words and stalls.
// Expected bit streams come from the word/direction/parity rules, not from the design.
`timescale 1ns/1ps
module tb_usr_tx_seq;

    localparam int W = 4;
`ifdef USR_TX_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_dir    = 1'b0;
    logic         ser_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready, ser_out, ser_valid, ser_last, busy;
    logic [1:0]   mode_out;

    int n_checks = 0;
    int n_fail   = 0;

    usr_tx_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .busy      (busy),
        .mode_out  (mode_out)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observations collected by xfer for the scenario tasks to judge.
    logic       beat_bit[$];
    logic       beat_last[$];
    logic [1:0] beat_mode[$];
    logic       stall_bit[$];
    logic       stall_last[$];
    logic [1:0] stall_mode[$];
    int         stall_idx[$];
    logic [1:0] acc_mode;
    int         acc_wait;
    logic       first_valid;
    int         shift_bad;
    logic       timed_out;
    logic       post_in_ready, post_busy, post_valid;
    logic [1:0] post_mode;
    logic [W-1:0] post_q;

    // Reference: bit i of the serial stream for word w sent in direction d.
    function automatic logic exp_bit(input logic [W-1:0] w, input logic d, input int i);
        if (i >= W) return ^w;
        return d ? w[W-1-i] : w[i];
    endfunction

    function automatic logic [1:0] exp_mode(input logic d, input int i);
        if (i >= W) return 2'b00;
        return d ? 2'b10 : 2'b01;
    endfunction

    // Called and returns in the low clock phase.
    task automatic xfer(input logic [W-1:0] word, input logic dir, input int stall_pct,
                        input int stall_beat, input int stall_len,
                        input logic hold_next, input logic [W-1:0] next_word);
        int cyc;
        int stalled;
        beat_bit.delete(); beat_last.delete(); beat_mode.delete();
        stall_bit.delete(); stall_last.delete(); stall_mode.delete(); stall_idx.delete();
        shift_bad = 0;
        timed_out = 1'b0;
        in_valid = 1'b1; in_data = word; in_dir = dir;
        #1;
        acc_wait = 0;
        while (!in_ready && acc_wait < 50) begin
            @(negedge clock); #1;
            acc_wait++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
            in_valid  = 1'b0;
            return;
        end
        acc_mode = mode_out;
        @(posedge clock);
        @(negedge clock);
        in_valid = hold_next;
        if (hold_next) in_data = next_word;
        cyc = 0;
        stalled = 0;
        while (beat_bit.size() < L && cyc < 300) begin
            if (stall_len > 0)
                ser_ready = !(beat_bit.size() == stall_beat && stalled < stall_len);
            else
                ser_ready = (int'($urandom_range(99)) >= stall_pct);
            #1;
            if (cyc == 0) first_valid = ser_valid;
            if (in_ready !== 1'b0 || busy !== 1'b1 || ser_valid !== 1'b1) shift_bad++;
            if (ser_ready) begin
                beat_bit.push_back(ser_out);
                beat_last.push_back(ser_last);
                beat_mode.push_back(mode_out);
            end else begin
                stall_bit.push_back(ser_out);
                stall_last.push_back(ser_last);
                stall_mode.push_back(mode_out);
                stall_idx.push_back(beat_bit.size());
                stalled++;
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        if (beat_bit.size() < L) timed_out = 1'b1;
        ser_ready = 1'b0;
        #1;
        post_in_ready = in_ready;
        post_busy     = busy;
        post_valid    = ser_valid;
        post_mode     = mode_out;
        post_q        = dut.u_core.q;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 4'b1111; ser_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        n_checks++;
        if ({ser_valid, busy, ser_last, ser_out} !== 4'b0000)
            $display("FAIL reset_outputs: valid/busy/last/out got %b%b%b%b expected 0000",
                     ser_valid, busy, ser_last, ser_out);
        n_checks++;
        if (mode_out !== 2'b00) begin
            n_fail++; $display("FAIL reset_mode: got %b expected 00", mode_out);
        end
        if ({ser_valid, busy, ser_last, ser_out} !== 4'b0000) n_fail++;
        reset = 1'b0; in_valid = 1'b0; ser_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({ser_valid, busy, ser_last, ser_out, mode_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle: valid/busy/last/out/mode got %b%b%b%b%b expected 000000",
                     ser_valid, busy, ser_last, ser_out, mode_out);
        end
        n_checks++;
        if (dut.u_core.q !== '0) begin
            n_fail++; $display("FAIL reset_q: got %b expected 0000", dut.u_core.q);
        end
    endtask

    task automatic test_lsb();
        logic [W-1:0] w = 4'b0011;
        xfer(w, 1'b0, 0, 0, 0, 1'b0, '0);
        n_checks++;
        if (timed_out) begin
            n_fail++; $display("FAIL lsb_timeout: got %0d beats expected %0d", beat_bit.size(), L);
            return;
        end
        n_checks++;
        if (acc_mode !== 2'b11) begin
            n_fail++; $display("FAIL lsb_load_mode: got %b expected 11", acc_mode);
        end
        for (int i = 0; i < L; i++) begin
            n_checks++;
            if (beat_bit[i] !== exp_bit(w, 1'b0, i) || beat_mode[i] !== exp_mode(1'b0, i)
                || beat_last[i] !== (i == L - 1)) begin
                n_fail++;
                $display("FAIL lsb_beat%0d: bit/mode/last got %b/%b/%b expected %b/%b/%b", i,
                         beat_bit[i], beat_mode[i], beat_last[i],
                         exp_bit(w, 1'b0, i), exp_mode(1'b0, i), i == L - 1);
            end
        end
        n_checks++;
        if (shift_bad != 0 || stall_bit.size() != 0) begin
            n_fail++; $display("FAIL lsb_flags: got %0d bad cycles expected 0", shift_bad);
        end
        n_checks++;
        if ({post_in_ready, post_busy, post_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL lsb_after: in_ready/busy/valid got %b%b%b expected 100",
                     post_in_ready, post_busy, post_valid);
        end
    endtask

    task automatic test_msb();
        logic [W-1:0] w = 4'b1010;
        xfer(w, 1'b1, 0, 0, 0, 1'b0, '0);
        n_checks++;
        if (timed_out) begin
            n_fail++; $display("FAIL msb_timeout: got %0d beats expected %0d", beat_bit.size(), L);
            return;
        end
        for (int i = 0; i < L; i++) begin
            n_checks++;
            if (beat_bit[i] !== exp_bit(w, 1'b1, i) || beat_mode[i] !== exp_mode(1'b1, i)) begin
                n_fail++;
                $display("FAIL msb_beat%0d: bit/mode got %b/%b expected %b/%b", i,
                         beat_bit[i], beat_mode[i], exp_bit(w, 1'b1, i), exp_mode(1'b1, i));
            end
        end
        n_checks++;
        if (post_q !== '0) begin
            n_fail++; $display("FAIL msb_q_empty: got %b expected 0000", post_q);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] w = 4'b0111;
        xfer(w, 1'b0, 0, 1, 3, 1'b0, '0);
        n_checks++;
        if (timed_out || stall_bit.size() != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d stall cycles, %0d beats expected 3, %0d",
                     stall_bit.size(), beat_bit.size(), L);
            return;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (stall_bit[k] !== exp_bit(w, 1'b0, stall_idx[k]) || stall_mode[k] !== 2'b00
                || stall_last[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: bit/mode/last got %b/%b/%b expected %b/00/0", k,
                         stall_bit[k], stall_mode[k], stall_last[k], exp_bit(w, 1'b0, stall_idx[k]));
            end
        end
        for (int i = 0; i < L; i++) begin
            n_checks++;
            if (beat_bit[i] !== exp_bit(w, 1'b0, i)) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got %b expected %b", i, beat_bit[i], exp_bit(w, 1'b0, i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1 = W'($urandom);
        logic [W-1:0] w2 = W'($urandom);
        logic         d2 = 1'($urandom);
        xfer(w1, 1'b0, 0, 0, 0, 1'b1, w2);
        n_checks++;
        if (timed_out || shift_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d bad cycles, timeout %b expected 0, 0", shift_bad, timed_out);
        end
        n_checks++;
        if (post_in_ready !== 1'b1 || post_mode !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_idle_accept: in_ready/mode got %b/%b expected 1/11",
                     post_in_ready, post_mode);
        end
        xfer(w2, d2, 0, 0, 0, 1'b0, '0);
        n_checks++;
        if (timed_out || acc_wait != 0 || first_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: wait/first_valid got %0d/%b expected 0/1", acc_wait, first_valid);
        end
        for (int i = 0; i < beat_bit.size(); i++) begin
            n_checks++;
            if (beat_bit[i] !== exp_bit(w2, d2, i)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %b expected %b", i, beat_bit[i], exp_bit(w2, d2, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w = 4'b1100;
        logic [W-1:0] w2 = W'($urandom);
        logic         d2 = 1'($urandom);
        in_valid = 1'b1; in_data = w; in_dir = 1'b0;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0; ser_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ser_valid !== 1'b1 || ser_out !== exp_bit(w, 1'b0, i)) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: valid/out got %b/%b expected 1/%b", i,
                         ser_valid, ser_out, exp_bit(w, 1'b0, i));
            end
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; ser_ready = 1'b0;
        #1;
        n_checks++;
        if ({ser_valid, busy, ser_last, in_ready} !== 4'b0001 || dut.u_core.q !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: valid/busy/last/in_ready got %b%b%b%b q %b expected 0001 q 0000",
                     ser_valid, busy, ser_last, in_ready, dut.u_core.q);
        end
        xfer(w2, d2, 20, 0, 0, 1'b0, '0);
        n_checks++;
        if (timed_out) begin
            n_fail++; $display("FAIL rstmid_timeout: got %0d beats expected %0d", beat_bit.size(), L);
            return;
        end
        for (int i = 0; i < L; i++) begin
            n_checks++;
            if (beat_bit[i] !== exp_bit(w2, d2, i)) begin
                n_fail++;
                $display("FAIL rstmid_after%0d: got %b expected %b", i, beat_bit[i], exp_bit(w2, d2, i));
            end
        end
    endtask

`ifdef USR_TX_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2] = '{4'b0111, 4'b0011};
        logic         par   [2] = '{1'b1, 1'b0};
        for (int n = 0; n < 2; n++) begin
            xfer(words[n], 1'b0, 0, 0, 0, 1'b0, '0);
            n_checks++;
            if (timed_out) begin
                n_fail++; $display("FAIL par_timeout%0d: got %0d beats expected %0d", n, beat_bit.size(), L);
                continue;
            end
            n_checks++;
            if (beat_bit[W] !== par[n] || beat_mode[W] !== 2'b00) begin
                n_fail++;
                $display("FAIL par_bit%0d: bit/mode got %b/%b expected %b/00", n,
                         beat_bit[W], beat_mode[W], par[n]);
            end
            for (int i = 0; i < L; i++) begin
                n_checks++;
                if (beat_last[i] !== (i == W) || beat_bit[i] !== exp_bit(words[n], 1'b0, i)) begin
                    n_fail++;
                    $display("FAIL par_beat%0d_%0d: bit/last got %b/%b expected %b/%b", n, i,
                             beat_bit[i], beat_last[i], exp_bit(words[n], 1'b0, i), i == W);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] w = W'($urandom);
            logic         d = 1'($urandom);
            xfer(w, d, 35, 0, 0, 1'b0, '0);
            n_checks++;
            if (timed_out || shift_bad != 0 || acc_mode !== 2'b11) begin
                n_fail++;
                $display("FAIL rnd_frame%0d: timeout/bad/acc_mode got %b/%0d/%b expected 0/0/11",
                         n, timed_out, shift_bad, acc_mode);
                continue;
            end
            for (int i = 0; i < L; i++) begin
                n_checks++;
                if (beat_bit[i] !== exp_bit(w, d, i) || beat_mode[i] !== exp_mode(d, i)
                    || beat_last[i] !== (i == L - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_beat%0d: bit/mode/last got %b/%b/%b expected %b/%b/%b",
                             n, i, beat_bit[i], beat_mode[i], beat_last[i],
                             exp_bit(w, d, i), exp_mode(d, i), i == L - 1);
                end
            end
            for (int k = 0; k < stall_bit.size(); k++) begin
                n_checks++;
                if (stall_bit[k] !== exp_bit(w, d, stall_idx[k]) || stall_mode[k] !== 2'b00
                    || stall_last[k] !== (stall_idx[k] == L - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_stall%0d: bit/mode/last got %b/%b/%b expected %b/00/%b",
                             n, k, stall_bit[k], stall_mode[k], stall_last[k],
                             exp_bit(w, d, stall_idx[k]), stall_idx[k] == L - 1);
                end
            end
            n_checks++;
            if ({post_in_ready, post_busy, post_valid} !== 3'b100 || post_q !== '0) begin
                n_fail++;
                $display("FAIL rnd%0d_after: in_ready/busy/valid got %b%b%b q %b expected 100 q 0000",
                         n, post_in_ready, post_busy, post_valid, post_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb();
        test_msb();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef USR_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
